inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Parametrised instruction queue between the fetch stage and the decode/launch stage of the multi-issue pipeline; replaces the IF/ID pipeline register.
- Accepts up to FETCH_W instructions per cycle from fetch and presents up to ISSUE_W oldest instructions, with their PCs, to the decoders.
- Supports partial fetch groups, partial consumption and a single-cycle flush on redirect.

Parameters:
- FETCH_W, 2, instructions delivered by fetch per cycle (≥1).
- ISSUE_W, 2, instruction slots presented to decode per cycle (≥1).
- DEPTH, 8, queue entries; power of two, DEPTH ≥ FETCH_W and DEPTH ≥ ISSUE_W.
- ADDR_W, 32, PC width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch group present.
- fetch_pc  in  ADDR_W  PC of slot 0; PC of slot k = fetch_pc + 4k, modulo 2^ADDR_W.
- fetch_inst  in  32*FETCH_W  slot k occupies bits [32k+31:32k].
- fetch_mask  in  FETCH_W  valid slots; contiguous ones from bit 0.
- fetch_ready  out  1  queue has ≥FETCH_W free entries.
- issue_valid  out  ISSUE_W  slot j holds the j-th oldest entry; contiguous from bit 0.
- issue_inst  out  32*ISSUE_W  instruction per slot.
- issue_pc  out  ADDR_W*ISSUE_W  PC per slot.
- issue_accept  in  $clog2(ISSUE_W+1)  number of slots consumed this cycle.
- flush  in  1  discard all entries.
- count  out  CNT_W  current occupancy.

Behaviour:
- Storage: circular array of DEPTH {pc, inst} entries; head and tail pointers wrap modulo DEPTH; count register tracks occupancy. The full condition is count == DEPTH, not a pointer comparison.
- Reset (reset high at the edge): head = tail = count = 0. On the next cycle issue_valid = 0, issue_inst = 0, issue_pc = 0, fetch_ready = 1. Reset overrides every other input, including in mid-operation.
- fetch_ready = (DEPTH − count ≥ FETCH_W). It is combinational from registered count only and does not credit a same-cycle pop.
- Push: occurs when fetch_valid && fetch_ready && !flush.
  - n_push = number of leading ones in fetch_mask.
  - Slot k (k < n_push) is written at tail+k; tail advances by n_push.
  - fetch_mask = 0 with fetch_valid = 1 is a legal no-op push.
  - A non-contiguous mask is a protocol violation: only the leading ones are taken; a simulation assertion fires.
  - If fetch_valid is high while fetch_ready is low, the group is not taken; fetch holds it.
- Issue outputs are combinational from stored state:
  - issue_valid[j] = (j < count).
  - Slot j shows the entry at head+j, wrapping.
  - Invalid slots drive inst = 0 and pc = 0.
  - Latency: an entry written at edge t is visible from cycle t+1 (no same-cycle bypass).
- Pop: n_pop = min(issue_accept, count, ISSUE_W); head advances by n_pop.
  - issue_accept greater than the valid slot count is a protocol violation: the block clamps it and a simulation assertion fires.
- Simultaneous push and pop: count_next = count + n_push − n_pop. Never overflows, because fetch_ready is computed on the pre-pop count.
- Flush: highest priority below reset. Push and pop in the same cycle are ignored. Next cycle head = tail = count = 0 and issue_valid = 0. Entries take effect again from the cycle after flush deasserts. Back-to-back flushes are legal.
- Ordering: strict FIFO across wrap-around. The PC stored with each entry is exact; no recomputation on read.

Test Plan:
- Reset with DEPTH=8, FETCH_W=2, ISSUE_W=2, then idle → count=0, issue_valid=00, fetch_ready=1, all issue_inst/issue_pc = 0.
- Four pushes of mask=11 at fetch_pc=0x100, 0x108, 0x110, 0x118, no accept → count 2,4,6,8. fetch_ready drops once count=8 (also low whenever count>6). Slot0 pc=0x100, slot1 pc=0x104. A fifth push held with fetch_valid=1 is not taken.
- Partial group: fetch_mask=01, fetch_pc=0x200 → count+1, only pc 0x200 stored. Next push at 0x208 issues 0x200 then 0x208 in order.
- Steady state, count=4, push mask=11 + accept=2 every cycle for 20 cycles → count stays 4. PCs strictly increasing by 4 across pointer wrap; no loss or duplication.
- Flush at count=6 with simultaneous push mask=11 and accept=1 → next cycle count=0, issue_valid=00. A push on the following cycle at 0x400 appears at slot0 one cycle later.
- Over-accept: count=1, issue_accept=2 → n_pop=1, count=0, no underflow, assertion reported. Reset asserted mid-stream at count=5 → count=0 next cycle.

Source files
------------

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Purpose  : Instruction queue between fetch and decode/launch. Accepts up to
//            FETCH_W instructions per cycle, presents the ISSUE_W oldest
//            entries (with PCs) to decode, supports partial groups, partial
//            consumption and a single-cycle flush.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            fetch_valid/pc/inst/mask, fetch_ready - fetch-side push port
//            issue_valid/inst/pc, issue_accept     - decode-side pop port
//            flush             - discard all entries
//            count             - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fetch_valid,
  input  logic [ADDR_W-1:0]           fetch_pc,
  input  logic [32*FETCH_W-1:0]       fetch_inst,
  input  logic [FETCH_W-1:0]          fetch_mask,
  output logic                        fetch_ready,
  output logic [ISSUE_W-1:0]          issue_valid,
  output logic [32*ISSUE_W-1:0]       issue_inst,
  output logic [ADDR_W*ISSUE_W-1:0]   issue_pc,
  input  logic [$clog2(ISSUE_W+1)-1:0] issue_accept,
  input  logic                        flush,
  output logic [CNT_W-1:0]            count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [31:0]       inst_mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [CNT_W-1:0]  n_push;
  logic [CNT_W-1:0]  n_pop;
  logic [CNT_W-1:0]  accept_ext;
  logic [CNT_W-1:0]  avail;
  logic              push_en;

  // Ready looks only at the registered count so a same-cycle pop is never
  // credited; this is what makes overflow impossible.
  assign fetch_ready = ((CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W));
  assign push_en     = fetch_valid && fetch_ready && !flush;
  assign count       = count_q;

  // Leading-ones count of the mask: stops at the first hole, so a malformed
  // mask still yields a contiguous group.
  always_comb begin
    logic run;
    n_push = '0;
    run    = 1'b1;
    for (int k = 0; k < FETCH_W; k++) begin
      if (run && fetch_mask[k]) begin
        n_push = CNT_W'(k + 1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Pop is clamped to both the occupancy and the number of issue slots.
  always_comb begin
    accept_ext = CNT_W'(issue_accept);
    avail      = (count_q < CNT_W'(ISSUE_W)) ? count_q : CNT_W'(ISSUE_W);
    n_pop      = (accept_ext < avail) ? accept_ext : avail;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_pop);
      if (push_en) begin
        tail_d = tail_q + PTR_W'(n_push);
      end
      count_d = count_q + (push_en ? n_push : '0) - n_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: unoccupied entries are masked at the outputs.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (CNT_W'(k) < n_push) begin
          pc_mem_q[tail_q + PTR_W'(k)]   <= fetch_pc + ADDR_W'(4 * k);
          inst_mem_q[tail_q + PTR_W'(k)] <= fetch_inst[32*k +: 32];
        end
      end
    end
  end

  // Issue slot j shows the j-th oldest entry, zeroed when not occupied.
  for (genvar j = 0; j < ISSUE_W; j++) begin : g_issue
    logic [PTR_W-1:0] idx;
    assign idx                          = head_q + PTR_W'(j);
    assign issue_valid[j]               = (CNT_W'(j) < count_q);
    assign issue_inst[32*j +: 32]       = issue_valid[j] ? inst_mem_q[idx] : '0;
    assign issue_pc[ADDR_W*j +: ADDR_W] = issue_valid[j] ? pc_mem_q[idx] : '0;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (fetch_valid && fetch_ready) begin
        assert ((fetch_mask & (fetch_mask + FETCH_W'(1))) == '0)
          else $warning("inst_queue: non-contiguous fetch_mask %b", fetch_mask);
      end
      assert (accept_ext <= avail)
        else $warning("inst_queue: issue_accept %0d exceeds valid slots %0d",
                      accept_ext, avail);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_queue
// Purpose  : Self-checking bench for inst_queue. A queue-of-entries reference
//            model tracks the expected contents; directed scenarios plus a
//            randomized run compare the DUT outputs against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ACC_W   = $clog2(ISSUE_W + 1);

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      fetch_valid;
  logic [ADDR_W-1:0]         fetch_pc;
  logic [32*FETCH_W-1:0]     fetch_inst;
  logic [FETCH_W-1:0]        fetch_mask;
  logic                      fetch_ready;
  logic [ISSUE_W-1:0]        issue_valid;
  logic [32*ISSUE_W-1:0]     issue_inst;
  logic [ADDR_W*ISSUE_W-1:0] issue_pc;
  logic [ACC_W-1:0]          issue_accept;
  logic                      flush;
  logic [CNT_W-1:0]          count;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
  } ent_t;
  ent_t mq[$];

  inst_queue #(
    .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .fetch_mask(fetch_mask), .fetch_ready(fetch_ready),
    .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_pc(issue_pc),
    .issue_accept(issue_accept), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  // ---- reference model accessors ----
  function automatic logic [ISSUE_W-1:0] exp_valid();
    logic [ISSUE_W-1:0] v = '0;
    for (int j = 0; j < ISSUE_W; j++) v[j] = (j < mq.size());
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] exp_pc(int j);
    return (j < mq.size()) ? mq[j].pc : '0;
  endfunction

  function automatic logic [31:0] exp_inst(int j);
    return (j < mq.size()) ? mq[j].inst : '0;
  endfunction

  function automatic logic exp_ready();
    return (DEPTH - mq.size()) >= FETCH_W;
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic cycle();
    int sz = mq.size();
    int npop;
    int nlead;
    if (reset || flush) begin
      mq.delete();
    end else begin
      npop = issue_accept;
      if (npop > sz) npop = sz;
      if (npop > ISSUE_W) npop = ISSUE_W;
      repeat (npop) void'(mq.pop_front());
      if (fetch_valid && (DEPTH - sz >= FETCH_W)) begin
        nlead = 0;
        while (nlead < FETCH_W && fetch_mask[nlead]) nlead++;
        for (int k = 0; k < nlead; k++)
          mq.push_back('{pc: fetch_pc + ADDR_W'(4 * k), inst: fetch_inst[32*k +: 32]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset        = 1'b0;
    fetch_valid  = 1'b0;
    fetch_pc     = '0;
    fetch_inst   = '0;
    fetch_mask   = '0;
    issue_accept = '0;
    flush        = 1'b0;
  endtask

  task automatic drive_push(input logic [ADDR_W-1:0] pc, input logic [FETCH_W-1:0] mask);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_mask  = mask;
    for (int k = 0; k < FETCH_W; k++) fetch_inst[32*k +: 32] = $urandom;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    vectors++;
    if (count !== 0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++;
    if (issue_valid !== '0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", issue_valid); end
    vectors++;
    if (issue_inst !== '0 || issue_pc !== '0) begin
      miscompares++; $display("FAIL reset_data: inst %h pc %h expected 0", issue_inst, issue_pc);
    end
    vectors++;
    if (fetch_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", fetch_ready); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_push(ADDR_W'(32'h100 + 8 * i), 2'b11);
      cycle();
      vectors++;
      if (count !== CNT_W'(2 * (i + 1))) begin
        miscompares++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, 2 * (i + 1));
      end
      vectors++;
      if (fetch_ready !== ((2 * (i + 1)) <= DEPTH - FETCH_W)) begin
        miscompares++; $display("FAIL fill_ready[%0d]: got %b", i, fetch_ready);
      end
    end
    // Fifth group held while full.
    drive_push(ADDR_W'(32'h120), 2'b11);
    cycle();
    vectors++;
    if (count !== CNT_W'(8)) begin miscompares++; $display("FAIL fill_hold_count: got %0d expected 8", count); end
    vectors++;
    if (issue_pc[0 +: ADDR_W] !== 32'h100 || issue_pc[ADDR_W +: ADDR_W] !== 32'h104) begin
      miscompares++; $display("FAIL fill_pcs: got %h expected 0000010400000100", issue_pc);
    end
    vectors++;
    if (issue_inst !== {exp_inst(1), exp_inst(0)}) begin
      miscompares++; $display("FAIL fill_inst: got %h expected %h", issue_inst, {exp_inst(1), exp_inst(0)});
    end
    idle_inputs();
  endtask

  task automatic test_partial();
    do_reset();
    drive_push(ADDR_W'(32'h200), 2'b01);
    cycle();
    vectors++;
    if (count !== 1 || issue_valid !== 2'b01 || issue_pc[0 +: ADDR_W] !== 32'h200) begin
      miscompares++; $display("FAIL partial_one: count %0d valid %b pc %h expected 1 01 200",
                              count, issue_valid, issue_pc[0 +: ADDR_W]);
    end
    drive_push(ADDR_W'(32'h208), 2'b11);
    cycle();
    idle_inputs();
    vectors++;
    if (count !== 3 || issue_pc[0 +: ADDR_W] !== 32'h200 || issue_pc[ADDR_W +: ADDR_W] !== 32'h208) begin
      miscompares++; $display("FAIL partial_order: count %0d pcs %h expected 3 00000208_00000200", count, issue_pc);
    end
    issue_accept = 1;
    cycle();
    issue_accept = 0;
    vectors++;
    if (issue_pc[0 +: ADDR_W] !== 32'h208 || issue_pc[ADDR_W +: ADDR_W] !== 32'h20c) begin
      miscompares++; $display("FAIL partial_pop: pcs %h expected 0000020c_00000208", issue_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] pc = 32'h1000;
    do_reset();
    repeat (2) begin drive_push(pc, 2'b11); pc += 8; cycle(); end
    for (int i = 0; i < 20; i++) begin
      drive_push(pc, 2'b11);
      pc += 8;
      issue_accept = 2;
      cycle();
      vectors++;
      if (count !== 4 || issue_pc !== {exp_pc(1), exp_pc(0)} ||
          issue_pc[ADDR_W +: ADDR_W] !== issue_pc[0 +: ADDR_W] + 4 ||
          issue_pc[0 +: ADDR_W] !== ADDR_W'(32'h1000 + 8 * (i + 1))) begin
        miscompares++; $display("FAIL steady[%0d]: count %0d pcs %h expected 4 %h", i, count, issue_pc,
                                {exp_pc(1), exp_pc(0)});
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive_push(ADDR_W'(32'h300 + 8 * i), 2'b11); cycle(); end
    drive_push(ADDR_W'(32'h318), 2'b11);
    issue_accept = 1;
    flush = 1'b1;
    cycle();
    vectors++;
    if (count !== 0 || issue_valid !== 2'b00) begin
      miscompares++; $display("FAIL flush_clear: count %0d valid %b expected 0 00", count, issue_valid);
    end
    cycle(); // back-to-back flush, inputs still asserted
    vectors++;
    if (count !== 0) begin miscompares++; $display("FAIL flush_twice: count %0d expected 0", count); end
    idle_inputs();
    drive_push(ADDR_W'(32'h400), 2'b11);
    cycle();
    idle_inputs();
    vectors++;
    if (count !== 2 || issue_pc[0 +: ADDR_W] !== 32'h400 || issue_inst !== {exp_inst(1), exp_inst(0)}) begin
      miscompares++; $display("FAIL flush_refill: count %0d pc0 %h expected 2 400", count, issue_pc[0 +: ADDR_W]);
    end
  endtask

  task automatic test_over_accept();
    do_reset();
    drive_push(ADDR_W'(32'h500), 2'b01);
    cycle();
    idle_inputs();
    issue_accept = 2;
    cycle();
    vectors++;
    if (count !== 0 || issue_valid !== 2'b00) begin
      miscompares++; $display("FAIL over_accept: count %0d valid %b expected 0 00", count, issue_valid);
    end
    cycle();
    vectors++;
    if (count !== 0) begin miscompares++; $display("FAIL over_accept_empty: count %0d expected 0", count); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_push(ADDR_W'(32'h600), 2'b11); cycle();
    drive_push(ADDR_W'(32'h608), 2'b11); cycle();
    drive_push(ADDR_W'(32'h610), 2'b01); cycle();
    vectors++;
    if (count !== 5) begin miscompares++; $display("FAIL mid_prefill: count %0d expected 5", count); end
    drive_push(ADDR_W'(32'h614), 2'b11);
    issue_accept = 1;
    reset = 1'b1;
    cycle();
    idle_inputs();
    vectors++;
    if (count !== 0 || issue_valid !== 2'b00 || fetch_ready !== 1'b1 || issue_pc !== '0) begin
      miscompares++; $display("FAIL mid_reset: count %0d valid %b ready %b expected 0 00 1",
                              count, issue_valid, fetch_ready);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] pc = 32'h8000;
    int n, lim;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      if ($urandom_range(0, 3) != 0) begin
        n = $urandom_range(0, FETCH_W);
        drive_push(pc, FETCH_W'((1 << n) - 1));
        if (exp_ready()) pc += ADDR_W'(4 * n);
      end
      lim = (mq.size() < ISSUE_W) ? mq.size() : ISSUE_W;
      issue_accept = ACC_W'($urandom_range(0, lim));
      flush = ($urandom_range(0, 29) == 0);
      cycle();
      vectors++;
      if (count !== CNT_W'(mq.size()) || fetch_ready !== exp_ready() || issue_valid !== exp_valid()) begin
        miscompares++; $display("FAIL rand_ctl[%0d]: count %0d ready %b valid %b expected %0d %b %b",
                                i, count, fetch_ready, issue_valid, mq.size(), exp_ready(), exp_valid());
      end
      for (int j = 0; j < ISSUE_W; j++) begin
        vectors++;
        if (issue_pc[ADDR_W*j +: ADDR_W] !== exp_pc(j) || issue_inst[32*j +: 32] !== exp_inst(j)) begin
          miscompares++; $display("FAIL rand_slot[%0d][%0d]: pc %h inst %h expected %h %h", i, j,
                                  issue_pc[ADDR_W*j +: ADDR_W], issue_inst[32*j +: 32], exp_pc(j), exp_inst(j));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_partial();
    test_back_to_back();
    test_flush();
    test_over_accept();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
